// File: rtl/ssd_bcd_counter.sv
// ---------------------------------------------------------------------------
// ssd_bcd_counter
//
// Four-digit BCD up/down counter, advanced by rising edges of a slow divided
// clock (tick_in), and shown on a multiplexed four-digit common-anode
// seven-segment display. tick_in is treated as data. It is synchronised and
// edge-detected, so the whole block runs on clk_in.
//
// Parameters
//   REFRESH_DIV : digit dwell is REFRESH_DIV+1 clk_in cycles
//   BLANK_LZ    : 1 = blank leading zero digits (digit 0 is never blanked)
//
// Ports
//   clk_in    : system clock
//   rst       : asynchronous reset, active low
//   tick_in   : divided clock; each rising edge is one count step
//   en        : count enable (steps arriving while low are dropped)
//   up        : 1 = increment, 0 = decrement
//   clr       : synchronous clear to 0000 (beats a simultaneous step)
//   count_bcd : registered count {d3,d2,d1,d0}
//   wrap      : one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)
//   an        : digit anodes, active low
//   seg       : segments {g,f,e,d,c,b,a}, active low
// ---------------------------------------------------------------------------
module ssd_bcd_counter #(
  parameter logic [15:0] REFRESH_DIV = 16'd24999,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] count_bcd,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  // tick_in synchroniser: sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3 (delay)
  logic [2:0]  sync_q, sync_d;
  // warm_q[2] is set once s3 holds a real sample of tick_in. A tick_in
  // already high at reset release must not look like a rising edge.
  logic [2:0]  warm_q, warm_d;
  logic        step;

  logic [15:0] count_q, count_d;
  logic        wrap_q, wrap_d;
  logic [15:0] inc_val, dec_val;
  logic        inc_carry, dec_borrow;

  logic [15:0] refresh_q, refresh_d;
  logic [1:0]  sel_q, sel_d;

  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  digit;
  logic        lz1, lz2, lz3;
  logic        blank;

  // -------------------------------------------------------------------------
  // Edge detect
  // -------------------------------------------------------------------------
  always_comb begin
    sync_d = {sync_q[1:0], tick_in};
    warm_d = {warm_q[1:0], 1'b1};
    step   = sync_q[1] & ~sync_q[2] & warm_q[2];
  end

  // -------------------------------------------------------------------------
  // BCD increment / decrement, ripple carry/borrow digit by digit.
  // A carry (borrow) that leaves digit 3 is the wrap condition.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    inc_val    = count_q;
    dec_val    = count_q;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          // Out-of-range digits are unreachable. They are clamped back into 0-9 anyway.
          dec_val[4*i +: 4] = (count_q[4*i +: 4] > 4'd9) ? 4'd9
                                                         : count_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = 16'h0000;
    end else if (step && en) begin
      if (up) begin
        count_d = inc_val;
        wrap_d  = inc_carry;
      end else begin
        count_d = dec_val;
        wrap_d  = dec_borrow;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Refresh counter and digit select (free-running)
  // -------------------------------------------------------------------------
  always_comb begin
    refresh_d = refresh_q + 16'd1;
    sel_d     = sel_q;
    if (refresh_q >= REFRESH_DIV) begin
      refresh_d = 16'd0;
      sel_d     = sel_q + 2'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Display decode: selected digit, leading-zero blanking, segment table
  // -------------------------------------------------------------------------
  always_comb begin
    lz3   = (count_q[15:12] == 4'd0);
    lz2   = lz3 && (count_q[11:8] == 4'd0);
    lz1   = lz2 && (count_q[7:4] == 4'd0);
    digit = count_q[3:0];
    blank = 1'b0;
    case (sel_q)
      2'd1: begin digit = count_q[7:4];   blank = lz1; end
      2'd2: begin digit = count_q[11:8];  blank = lz2; end
      2'd3: begin digit = count_q[15:12]; blank = lz3; end
      default: begin digit = count_q[3:0]; blank = 1'b0; end
    endcase
    blank = blank && BLANK_LZ;

    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase

    an_d = ~(4'b0001 << sel_q);
    if (blank) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_q    <= 3'b000;
      warm_q    <= 3'b000;
      count_q   <= 16'h0000;
      wrap_q    <= 1'b0;
      refresh_q <= 16'd0;
      sel_q     <= 2'd0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      sync_q    <= sync_d;
      warm_q    <= warm_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_ssd_bcd_counter.sv
// ---------------------------------------------------------------------------
// Testbench for ssd_bcd_counter. Two instances share every input. dut has
// leading-zero blanking and dut_nb does not. Both use REFRESH_DIV=3, which
// gives a 4-cycle digit dwell. Inputs change on the falling edge of clk_in.
// Outputs are sampled on the falling edge, or 1 time unit after a rising
// edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ssd_bcd_counter;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        tick_in, en, up, clr;
  logic [15:0] count_bcd, count_bcd_nb;
  logic        wrap, wrap_nb;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  ssd_bcd_counter #(.REFRESH_DIV(16'd3), .BLANK_LZ(1'b1)) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .en(en), .up(up), .clr(clr),
    .count_bcd(count_bcd), .wrap(wrap), .an(an), .seg(seg)
  );

  ssd_bcd_counter #(.REFRESH_DIV(16'd3), .BLANK_LZ(1'b0)) dut_nb (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .en(en), .up(up), .clr(clr),
    .count_bcd(count_bcd_nb), .wrap(wrap_nb), .an(an_nb), .seg(seg_nb)
  );

  // One complete tick_in pulse: 3 cycles high, then 3 cycles low.
  task automatic tick_pulse();
    @(negedge clk_in) tick_in = 1'b1;
    repeat (3) @(negedge clk_in);
    tick_in = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic do_clear();
    @(negedge clk_in) clr = 1'b1;
    @(negedge clk_in) clr = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; tick_in = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (count_bcd !== 16'h0000) begin
      errors++; $display("FAIL reset_count: got %h expected 0000", count_bcd);
    end
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || wrap !== 1'b0) begin
      errors++; $display("FAIL reset_display: got an=%b seg=%b wrap=%b expected 1111 1111111 0", an, seg, wrap);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'b1111) begin
      errors++; $display("FAIL reset_first_cycle_an: got %b expected 1111", an);
    end
    // tick_in still high: must not produce a step
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      checks++;
      if (count_bcd !== 16'h0000 || wrap !== 1'b0) begin
        errors++; $display("FAIL reset_no_step: cycle %0d got count=%h wrap=%b expected 0000 0", i, count_bcd, wrap);
      end
    end
    tick_in = 1'b0;
    repeat (3) @(negedge clk_in);
    tick_pulse();
    checks++;
    if (count_bcd !== 16'h0001) begin
      errors++; $display("FAIL reset_first_tick: got %h expected 0001", count_bcd);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_step_latency();
    do_clear();
    up = 1'b1; en = 1'b1;
    for (int i = 0; i < 999; i++) tick_pulse();
    checks++;
    if (count_bcd !== 16'h0999) begin
      errors++; $display("FAIL preload_0999: got %h expected 0999", count_bcd);
    end
    @(negedge clk_in) tick_in = 1'b1;
    @(posedge clk_in) #1;   // edge k
    checks++;
    if (count_bcd !== 16'h0999) begin
      errors++; $display("FAIL latency_edge1: got %h expected 0999", count_bcd);
    end
    @(posedge clk_in) #1;   // edge k+1
    checks++;
    if (count_bcd !== 16'h0999) begin
      errors++; $display("FAIL latency_edge2: got %h expected 0999", count_bcd);
    end
    @(posedge clk_in) #1;   // edge k+2
    checks++;
    if (count_bcd !== 16'h1000 || wrap !== 1'b0) begin
      errors++; $display("FAIL latency_edge3: got count=%h wrap=%b expected 1000 0", count_bcd, wrap);
    end
    @(negedge clk_in) tick_in = 1'b0;
    repeat (6) @(negedge clk_in);
    checks++;
    if (count_bcd !== 16'h1000 || wrap !== 1'b0) begin
      errors++; $display("FAIL falling_edge_no_step: got count=%h wrap=%b expected 1000 0", count_bcd, wrap);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    logic        dir_tab [3];
    logic [15:0] exp_tab [3];
    dir_tab[0] = 1'b0; exp_tab[0] = 16'h9999;
    dir_tab[1] = 1'b1; exp_tab[1] = 16'h0000;
    dir_tab[2] = 1'b0; exp_tab[2] = 16'h9999;
    do_clear();
    checks++;
    if (count_bcd !== 16'h0000) begin
      errors++; $display("FAIL clear: got %h expected 0000", count_bcd);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in) begin up = dir_tab[i]; tick_in = 1'b1; end
      @(posedge clk_in);
      @(posedge clk_in);
      @(posedge clk_in) #1;
      checks++;
      if (count_bcd !== exp_tab[i] || wrap !== 1'b1) begin
        errors++; $display("FAIL wrap_%0d: got count=%h wrap=%b expected %h 1", i, count_bcd, wrap, exp_tab[i]);
      end
      @(posedge clk_in) #1;
      checks++;
      if (count_bcd !== exp_tab[i] || wrap !== 1'b0) begin
        errors++; $display("FAIL wrap_width_%0d: got count=%h wrap=%b expected %h 0", i, count_bcd, wrap, exp_tab[i]);
      end
      @(negedge clk_in) tick_in = 1'b0;
      repeat (3) @(negedge clk_in);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_controls();
    // count is 9999 and up=0 here
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick_pulse();
    checks++;
    if (count_bcd !== 16'h9999) begin
      errors++; $display("FAIL enable_hold: got %h expected 9999", count_bcd);
    end
    @(negedge clk_in) en = 1'b1;
    repeat (5) @(negedge clk_in);
    checks++;
    if (count_bcd !== 16'h9999) begin
      errors++; $display("FAIL enable_not_queued: got %h expected 9999", count_bcd);
    end

    do_clear();
    up = 1'b1;
    for (int i = 0; i < 42; i++) tick_pulse();
    checks++;
    if (count_bcd !== 16'h0042) begin
      errors++; $display("FAIL preload_0042: got %h expected 0042", count_bcd);
    end
    // step is high between edges k+1 and k+2; clr is applied at edge k+2
    @(negedge clk_in) tick_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in) clr = 1'b1;
    @(posedge clk_in) #1;
    checks++;
    if (count_bcd !== 16'h0000 || wrap !== 1'b0) begin
      errors++; $display("FAIL clr_beats_step: got count=%h wrap=%b expected 0000 0", count_bcd, wrap);
    end
    @(negedge clk_in) begin clr = 1'b0; tick_in = 1'b0; end
    repeat (4) @(negedge clk_in);
    checks++;
    if (count_bcd !== 16'h0000) begin
      errors++; $display("FAIL clr_step_lost: got %h expected 0000", count_bcd);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_scan();
    logic [3:0] exp_an  [5];
    logic [6:0] exp_seg [5];
    logic [3:0] prev_an;
    bit         found;
    exp_an[0] = 4'b1110; exp_seg[0] = 7'b0010010;
    exp_an[1] = 4'b1101; exp_seg[1] = 7'b1000000;
    exp_an[2] = 4'b1011; exp_seg[2] = 7'b0110000;
    exp_an[3] = 4'b1111; exp_seg[3] = 7'b1111111;
    exp_an[4] = 4'b1110; exp_seg[4] = 7'b0010010;

    up = 1'b1;
    for (int i = 0; i < 305; i++) tick_pulse();
    checks++;
    if (count_bcd !== 16'h0305) begin
      errors++; $display("FAIL preload_0305: got %h expected 0305", count_bcd);
    end

    // align to the first cycle in which digit 0 is lit
    found   = 1'b0;
    prev_an = an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_in);
      if (an === 4'b1110 && prev_an !== 4'b1110) found = 1'b1;
      else prev_an = an;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL scan_align: got an=%b expected 1110 within 40 cycles", an);
    end else begin
      for (int j = 0; j <= 16; j++) begin
        if (j > 0) @(negedge clk_in);
        checks++;
        if (an !== exp_an[j/4] || seg !== exp_seg[j/4]) begin
          errors++; $display("FAIL scan_cycle_%0d: got an=%b seg=%b expected %b %b", j, an, seg, exp_an[j/4], exp_seg[j/4]);
        end
        if (j >= 12 && j <= 15) begin
          checks++;
          if (an_nb !== 4'b0111 || seg_nb !== 7'b1000000) begin
            errors++; $display("FAIL scan_noblank_%0d: got an=%b seg=%b expected 0111 1000000", j, an_nb, seg_nb);
          end
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_in);
      if (an === 4'b1011) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL arst_align: got an=%b expected 1011 within 40 cycles", an);
    end
    @(posedge clk_in);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || count_bcd !== 16'h0000 || wrap !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: got an=%b seg=%b count=%h wrap=%b expected 1111 1111111 0000 0", an, seg, count_bcd, wrap);
    end
    checks++;
    if (an_nb !== 4'b1111 || count_bcd_nb !== 16'h0000) begin
      errors++; $display("FAIL arst_immediate_nb: got an=%b count=%h expected 1111 0000", an_nb, count_bcd_nb);
    end
    @(negedge clk_in) rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk_in) #1;
      checks++;
      if (e <= 4) begin
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
          errors++; $display("FAIL arst_restart_%0d: got an=%b seg=%b expected 1110 1000000", e, an, seg);
        end
      end else begin
        if (an !== 4'b1111 || seg !== 7'b1111111) begin
          errors++; $display("FAIL arst_restart_%0d: got an=%b seg=%b expected 1111 1111111", e, an, seg);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_step_latency();
    test_wrap();
    test_controls();
    do_clear();
    test_scan();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ssd_bcd_counter.md
Name: ssd_bcd_counter

Overview:
Consumes the slow toggling clock produced by the team's clock divider and turns it into a 4-digit BCD up/down counter shown on a multiplexed 4-digit common-anode seven-segment display. The divided clock is treated as data: it is synchronised into clk_in and edge-detected, so the whole block runs on one clock. Digit multiplexing uses its own refresh counter.

Parameters:
REFRESH_DIV, 16'd24999, digit dwell is REFRESH_DIV+1 clk_in cycles (1 kHz digit rate at 25 MHz).
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked); 0 = show all digits.

Ports:
clk_in  input  1  system clock, 25 MHz
rst  input  1  asynchronous, active-low reset
tick_in  input  1  divided clock from the clock divider; counted on rising edges only
en  input  1  count enable; 0 holds the count
up  input  1  1 = increment, 0 = decrement
clr  input  1  synchronous clear of the count to 0000
count_bcd  output  16  registered count {d3,d2,d1,d0}, 4 bits per BCD digit
wrap  output  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)
an  output  4  digit anodes, active-low, one-hot when a digit is lit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst=0, async): count_bcd=0, wrap=0, an=4'b1111, seg=7'b1111111, sync flops=0, refresh counter=0, digit select=0. Releasing rst creates no step, even if tick_in=1.
- tick_in sync: 2-flop synchroniser, then a third delay flop. step = s2 & ~s3.
- Latency: tick_in rises before clk_in edge k. s1 goes high at edge k and s2 at edge k+1. count_bcd and wrap update at edge k+2.
- Counter priority per cycle: clr first (count=0, wrap=0), then step&en, then hold. step while en=0 is dropped, not queued.
- Increment: d0+1. A digit at 9 becomes 0 and carries to the next digit. 9999 goes to 0000 with wrap=1 for exactly one cycle.
- Decrement: a digit at 0 becomes 9 and borrows from the next digit. 0000 goes to 9999 with wrap=1.
- Every stored digit is always in the range 0-9.
- Refresh counter:
  - Counts 0..REFRESH_DIV.
  - At terminal count it returns to 0 and digit select advances 0->1->2->3->0.
  - It runs continuously, independent of en and clr.
- Display registers: an and seg are registered from the current digit select and count_bcd, so they lag both by one cycle.
  - Digit i lit: an[i]=0 and all other bits 1.
  - Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other value gives 1111111 (defensive).
- Blanking (BLANK_LZ=1): digit i>0 is blanked (an=4'b1111, seg=7'b1111111 for that slot) when it and every higher digit are 0. Digit 0 is always shown.
- Reset mid-count or mid-scan returns every register to its reset value immediately, asynchronously.
- Simultaneous clr and step: clr wins, no wrap pulse, and the step is lost.

Test Plan:
- Reset: hold rst=0 with tick_in=1, then release. Required: count_bcd=16'h0000, an=4'b1111 for the first cycle, and no count change until a new tick_in rising edge.
- Step latency and carry: preload to 0999 via up counting, en=1, up=1, one tick_in rise. Required: count_bcd=16'h1000 exactly 3 clk_in edges after the rise, and wrap stays 0. tick_in falling edges cause no change.
- Wrap both directions:
  - At 9999 with up=1, one tick gives 0000 with wrap high for exactly 1 cycle.
  - Then with up=0, one tick gives 9999 with wrap high for 1 cycle.
- Controls:
  - en=0 across 3 tick rises leaves the count unchanged.
  - clr=1 in the same cycle as step (count 0042) gives 0000 with wrap=0.
- Scan, with REFRESH_DIV=3 and count 0305, BLANK_LZ=1:
  - an cycles 1110 (seg 0010010), 1101 (1000000), 1011 (0110000), then 1111 for the blanked digit 3.
  - Each pattern lasts 4 clk_in cycles.
  - With BLANK_LZ=0, the digit 3 slot shows an=0111, seg=1000000.
- Async reset mid-scan: assert rst between clk_in edges while digit 2 is lit. Required: an=1111, seg=1111111 and count 0000 immediately. Scan restarts at digit 0.
